// File: rtl/bcd_display_sequencer.sv
// Binary-to-two-digit seven-segment sequencer.
// A loaded value is split into tens and units by repeated subtraction of ten,
// one step per clock through a single shared subtractor. Both digit patterns
// are registered in one step at the end of a conversion, so the displays never
// show intermediate values.
module bcd_display_sequencer #(
  parameter int WIDTH      = 6,
  parameter bit BLANK_LZ   = 1'b0,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] SW,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [6:0]       HEX_0,
  output logic [6:0]       HEX_1
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SUB    = 2'd1,
    ENCODE = 2'd2
  } state_t;

  // Active-high segment patterns, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_ZERO  = 7'b0111111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Reset values follow the same blanking and polarity rules as live results.
  localparam logic [6:0] HEX0_RAW_RST = SEG_ZERO;
  localparam logic [6:0] HEX1_RAW_RST = BLANK_LZ ? SEG_BLANK : SEG_ZERO;
  localparam logic [6:0] HEX0_RST     = ACTIVE_LOW ? ~HEX0_RAW_RST : HEX0_RAW_RST;
  localparam logic [6:0] HEX1_RST     = ACTIVE_LOW ? ~HEX1_RAW_RST : HEX1_RAW_RST;

  state_t     state_q, state_d;
  logic [6:0] rem_q,   rem_d;
  logic [3:0] tens_q,  tens_d;
  logic       done_q,  done_d;
  logic       ovf_q,   ovf_d;
  logic [6:0] hex0_q,  hex0_d;
  logic [6:0] hex1_q,  hex1_d;

  // Decimal digit to active-high segment pattern.
  function automatic logic [6:0] seg(input logic [3:0] digit);
    logic [6:0] s;
    case (digit)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // Apply the board's segment polarity just before the output register.
  function automatic logic [6:0] polarity(input logic [6:0] s);
    return ACTIVE_LOW ? ~s : s;
  endfunction

  // Next-state, subtract-by-ten datapath and result encoding.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    tens_d  = tens_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    hex0_d  = hex0_q;
    hex1_d  = hex1_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          rem_d   = 7'(SW);
          tens_d  = 4'd0;
          state_d = SUB;
        end
      end
      SUB: begin
        if (rem_q >= 7'd10) begin
          rem_d  = rem_q - 7'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          state_d = ENCODE;
        end
      end
      ENCODE: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (tens_q > 4'd9) begin
          ovf_d  = 1'b1;
          hex0_d = polarity(SEG_DASH);
          hex1_d = polarity(SEG_DASH);
        end else begin
          ovf_d  = 1'b0;
          // rem is below ten here, so its low nibble is the units digit.
          hex0_d = polarity(seg(rem_q[3:0]));
          if (BLANK_LZ && (tens_q == 4'd0)) begin
            hex1_d = polarity(SEG_BLANK);
          end else begin
            hex1_d = polarity(seg(tens_q));
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, working registers and output registers; reset aborts any conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= 7'd0;
      tens_q  <= 4'd0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      hex0_q  <= HEX0_RST;
      hex1_q  <= HEX1_RST;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tens_q  <= tens_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      hex0_q  <= hex0_d;
      hex1_q  <= hex1_d;
    end
  end

  // busy covers SUB and ENCODE, so it is already low in the done cycle.
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign HEX_0    = hex0_q;
  assign HEX_1    = hex1_q;

endmodule

// File: tb/tb_bcd_display_sequencer.sv
// Testbench for bcd_display_sequencer: four instances with different
// parameters share clock, reset, load and switch inputs.
module tb_bcd_display_sequencer;

  localparam logic [6:0] ZERO  = 7'b0111111;
  localparam logic [6:0] NZERO = 7'b1000000;
  localparam logic [6:0] DASH  = 7'b1000000;
  localparam logic [6:0] ALL1  = 7'b1111111;
  localparam logic [6:0] NONE  = 7'b0000000;

  logic       clk, rst, load;
  logic [6:0] sw;

  logic       busy_a, done_a, ov_a;  logic [6:0] h0_a, h1_a;
  logic       busy_b, done_b, ov_b;  logic [6:0] h0_b, h1_b;
  logic       busy_w, done_w, ov_w;  logic [6:0] h0_w, h1_w;
  logic       busy_l, done_l, ov_l;  logic [6:0] h0_l, h1_l;

  int pass_cnt = 0;
  int total_cnt = 0;

  bcd_display_sequencer #(.WIDTH(6), .BLANK_LZ(1'b0), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst(rst), .SW(sw[5:0]), .load(load), .busy(busy_a), .done(done_a),
    .overflow(ov_a), .HEX_0(h0_a), .HEX_1(h1_a));
  bcd_display_sequencer #(.WIDTH(6), .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst(rst), .SW(sw[5:0]), .load(load), .busy(busy_b), .done(done_b),
    .overflow(ov_b), .HEX_0(h0_b), .HEX_1(h1_b));
  bcd_display_sequencer #(.WIDTH(7), .BLANK_LZ(1'b0), .ACTIVE_LOW(1'b0)) dut_w (
    .clk(clk), .rst(rst), .SW(sw), .load(load), .busy(busy_w), .done(done_w),
    .overflow(ov_w), .HEX_0(h0_w), .HEX_1(h1_w));
  bcd_display_sequencer #(.WIDTH(6), .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst(rst), .SW(sw[5:0]), .load(load), .busy(busy_l), .done(done_l),
    .overflow(ov_l), .HEX_0(h0_l), .HEX_1(h1_l));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         v;
    int         lat;
    logic [6:0] h1;
    logic [6:0] h0;
    logic       ov;
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_a_h0"}, h0_a, ZERO);
    check({tag, "_a_h1"}, h1_a, ZERO);
    check({tag, "_a_busy"}, busy_a, 0);
    check({tag, "_a_done"}, done_a, 0);
    check({tag, "_a_ov"}, ov_a, 0);
    check({tag, "_b_h0"}, h0_b, ZERO);
    check({tag, "_b_h1"}, h1_b, NONE);
    check({tag, "_w_h1"}, h1_w, ZERO);
    check({tag, "_w_ov"}, ov_w, 0);
    check({tag, "_l_h0"}, h0_l, NZERO);
    check({tag, "_l_h1"}, h1_l, ALL1);
    check({tag, "_l_done"}, done_l, 0);
  endtask

  // Drive one load strobe; returns just after the accepting edge E0.
  task automatic start(input int v);
    @(negedge clk);
    sw   = 7'(v);
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Count edges from E0 to done on instance a (sel 0) or w (sel 1).
  task automatic wait_done(input int sel, output int lat, output bit bsy_ok);
    lat    = -1;
    bsy_ok = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if ((sel == 0) ? done_a : done_w) begin
        lat = k;
        break;
      end
      if (((sel == 0) ? busy_a : busy_w) !== 1'b1) bsy_ok = 1'b0;
    end
  endtask

  initial begin
    int         lat, first, ndone;
    bit         bok;
    logic [6:0] e1b, e1l, e0l, c1, c0;

    rst  = 1'b1;
    load = 1'b0;
    sw   = 7'd0;
    tbl[0] = '{63, 8, 7'b1111101, 7'b1001111, 1'b0};
    tbl[1] = '{0,  2, 7'b0111111, 7'b0111111, 1'b0};
    tbl[2] = '{9,  2, 7'b0111111, 7'b1101111, 1'b0};
    tbl[3] = '{25, 4, 7'b1011011, 7'b1101101, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("idle");

    // Table-driven conversions, all instances in lockstep.
    for (int i = 0; i < 4; i++) begin
      start(tbl[i].v);
      check($sformatf("v%0d_busy_e0", tbl[i].v), busy_a, 1);
      wait_done(0, lat, bok);
      check($sformatf("v%0d_lat", tbl[i].v), lat, tbl[i].lat);
      check($sformatf("v%0d_busy_run", tbl[i].v), bok, 1);
      check($sformatf("v%0d_busy_done", tbl[i].v), busy_a, 0);
      check($sformatf("v%0d_h1", tbl[i].v), h1_a, tbl[i].h1);
      check($sformatf("v%0d_h0", tbl[i].v), h0_a, tbl[i].h0);
      check($sformatf("v%0d_ov", tbl[i].v), ov_a, tbl[i].ov);
      e1b = (tbl[i].v < 10) ? NONE : tbl[i].h1;
      e1l = ~e1b;
      e0l = ~tbl[i].h0;
      check($sformatf("v%0d_b_h1", tbl[i].v), h1_b, e1b);
      check($sformatf("v%0d_l_h1", tbl[i].v), h1_l, e1l);
      check($sformatf("v%0d_l_h0", tbl[i].v), h0_l, e0l);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_once", tbl[i].v), done_a, 0);
    end

    // Load while busy is ignored.
    start(40);
    @(posedge clk);
    @(negedge clk);
    sw   = 7'd17;
    load = 1'b1;
    @(posedge clk);
    #1;
    load  = 1'b0;
    first = -1;
    ndone = 0;
    c1    = 7'd0;
    c0    = 7'd0;
    for (int k = 3; k <= 15; k++) begin
      @(posedge clk);
      #1;
      if (done_a) begin
        ndone++;
        if (first < 0) begin
          first = k;
          c1 = h1_a;
          c0 = h0_a;
        end
      end
    end
    check("ign_first", first, 6);
    check("ign_ndone", ndone, 1);
    check("ign_h1", c1, 7'b1100110);
    check("ign_h0", c0, 7'b0111111);

    // Overflow on the 7-bit instance, then recovery.
    start(105);
    wait_done(1, lat, bok);
    check("ovf_lat", lat, 12);
    check("ovf_busy", bok, 1);
    check("ovf_flag", ov_w, 1);
    check("ovf_h1", h1_w, DASH);
    check("ovf_h0", h0_w, DASH);
    start(99);
    wait_done(1, lat, bok);
    check("v99_lat", lat, 11);
    check("v99_ov", ov_w, 0);
    check("v99_h1", h1_w, 7'b1101111);
    check("v99_h0", h0_w, 7'b1101111);
    repeat (2) @(posedge clk);

    // Asynchronous reset mid-conversion.
    start(57);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("abort");
    ndone = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done_a) ndone++;
    end
    check("abort_no_done", ndone, 0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back: second load presented in the done cycle.
    start(21);
    wait_done(0, lat, bok);
    check("b2b1_lat", lat, 4);
    check("b2b1_h1", h1_a, 7'b1011011);
    check("b2b1_h0", h0_a, 7'b0000110);
    sw   = 7'd10;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    check("b2b2_busy_e0", busy_a, 1);
    wait_done(0, lat, bok);
    check("b2b2_lat", lat, 3);
    check("b2b2_h1", h1_a, 7'b0000110);
    check("b2b2_h0", h0_a, 7'b0111111);
    check("b2b2_ov", ov_a, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bcd_display_sequencer.md
# bcd_display_sequencer

Sequential binary-to-two-digit seven-segment controller. It accepts a binary value on a load strobe and converts it to tens and units by iterative subtract-by-10, one subtraction per clock. It then registers both digit patterns and holds them until the next conversion completes. It sits between the switch/counter sources and the two on-board HEX displays, and replaces any combinational tens/units split with a single shared subtractor.

## Interface
- WIDTH, 6, binary input width; legal range 4..7
- BLANK_LZ, 0, 1 = tens digit blanked (all segments off) when tens == 0
- ACTIVE_LOW, 0, 1 = all segment outputs inverted (reset values included)

- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- SW  in  WIDTH  binary value to convert; sampled only on an accepted load
- load  in  1  conversion request; accepted only when busy == 0
- busy  out  1  high from the edge after acceptance until done
- done  out  1  one-cycle pulse; HEX_0/HEX_1/overflow updated on the same edge
- overflow  out  1  registered; 1 when the last converted value was >= 100
- HEX_0  out  7  units digit, bit0 = a … bit6 = g
- HEX_1  out  7  tens digit, same bit order

## Operation
- States: IDLE, SUB, ENCODE.
- IDLE:
  - On load == 1: rem <= SW (zero-extended to 7 bits), tens <= 0, go to SUB.
  - Otherwise stay in IDLE.
- SUB:
  - If rem >= 10: rem <= rem - 10, tens <= tens + 1, stay in SUB.
  - Otherwise go to ENCODE.
  - tens is 4 bits; its maximum is 12 for WIDTH = 7, so it never wraps.
- ENCODE, on one edge:
  - Register HEX_0 and HEX_1, assert done for the following cycle, return to IDLE.
  - If tens > 9: overflow <= 1 and both digits show dash (1000000).
  - Else: overflow <= 0, HEX_0 = seg(rem), HEX_1 = seg(tens).
  - If BLANK_LZ = 1 and tens == 0, HEX_1 = 0000000 instead.
- Active-high segment codes (gfedcba):
  - 0 = 0111111
  - 1 = 0000110
  - 2 = 1011011
  - 3 = 1001111
  - 4 = 1100110
  - 5 = 1101101
  - 6 = 1111101
  - 7 = 0000111
  - 8 = 1111111
  - 9 = 1101111
- ACTIVE_LOW = 1 inverts every bit at the output register.
- load while busy == 1 is ignored. It is not queued and SW is not sampled.
- Displays hold their last values for the whole conversion; there is no intermediate flicker.

## Timing
- Reset values:
  - State IDLE; busy = 0, done = 0, overflow = 0.
  - HEX_0 = HEX_1 = code for 0 (0111111). If BLANK_LZ = 1, HEX_1 = 0000000.
  - ACTIVE_LOW inverts these values.
- rst asserted mid-conversion aborts immediately (asynchronous). All outputs take their reset values and the pending result is discarded.
- Latency: let load be accepted at edge E0, with v = SW.
  - SUB occupies floor(v/10)+1 cycles.
  - ENCODE is entered at edge E0 + floor(v/10) + 1.
  - HEX/overflow update and done rise at edge E0 + floor(v/10) + 2.
- Worst case latency: 8 edges for WIDTH = 6 (v = 63); 14 edges for WIDTH = 7 (v = 127).
- busy is high from edge E0 up to the edge where done rises. It is low in the done cycle.
- done is high for exactly one cycle and is never asserted twice for one load.
- A load in the done cycle is accepted, because the block is in IDLE. Back-to-back conversions therefore need no gap.

## Test plan
- Reset then idle, defaults:
  - Expect HEX_1 = HEX_0 = 0111111, busy = 0, done = 0, overflow = 0.
  - Repeat with BLANK_LZ = 1: expect HEX_1 = 0000000.
- load with SW = 63, WIDTH = 6:
  - Expect busy for 8 cycles, then done at E0+8.
  - Expect HEX_1 = 1111101 (6), HEX_0 = 1001111 (3), overflow = 0.
- load with SW = 0 and SW = 9:
  - Expect done at E0+2.
  - Expect HEX_1 = 0111111, HEX_0 = 0111111 for 0 and 1101111 for 9.
- load with SW = 40, then pulse load with SW = 17 while busy:
  - Expect the second load ignored; the result shows 4 and 0 (1100110, 0111111).
  - Expect exactly one done pulse.
- WIDTH = 7, SW = 105:
  - Expect done at E0+12, overflow = 1, both HEX = 1000000.
  - Then load SW = 99: expect overflow = 0, both HEX = 1101111.
- Start SW = 57, assert rst at E0+3:
  - Expect all outputs at reset values and no done.
  - After release, load SW = 21 with load held high in the done cycle and SW = 10:
    - First result 2 and 1 (1011011, 0000110).
    - Second result 1 and 0 (0000110, 0111111).
    - Second done at its own E0+3.
